ms_es_by4_stream_decoder: RTL and testbench

- Stochastic-to-binary decoder: the far end of the by4 stochastic datapath.
- Consumes a unipolar stochastic bitstream 4 bits (lanes) per cycle and counts the ones.
- Early-stop mode: truncates the stream to a shorter observation window and rescales the count by shift.
- Returns a WXIP1-bit binary magnitude with a one-cycle done pulse; sits after the stochastic multiplier cores in arch_sweep.

---
 rtl/ms_es_by4_stream_decoder_pkg.sv | 37 +++
 rtl/ms_es_by4_stream_decoder_popcount.sv | 25 ++
 rtl/ms_es_by4_stream_decoder.sv | 146 ++++++++++++++
 tb/tb_ms_es_by4_stream_decoder.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ms_es_by4_stream_decoder_pkg.sv
// ---------------------------------------------------------------------------
// ms_es_dec_pkg
// Shared types and helpers for the by4 stochastic stream decoder.
//
// Contents:
//   state_t      - decoder FSM states (IDLE, ACCUM, DONE)
//   FULL_BEATS   - beats in a full-length stream for the default geometry
//   full_beats   - same quantity for an arbitrary geometry
//   clamp_trunc  - limits the early-stop shift so the window never drops
//                  below one beat of LANES bits
// ---------------------------------------------------------------------------
package ms_es_dec_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int DEF_DATA_WIDTH = 5;
   localparam int DEF_LANES      = 4;
   localparam int FULL_BEATS     = (2 ** DEF_DATA_WIDTH) / DEF_LANES;

   // Number of LANES-wide beats that make up a 2^dw bit stream.
   function automatic int unsigned full_beats(input int unsigned dw,
                                              input int unsigned lanes);
      return (32'd1 << dw) / lanes;
   endfunction

   // The smallest legal window is 4 bits (one by4 beat), so the shift is
   // capped at dw-2.
   function automatic int unsigned clamp_trunc(input int unsigned t,
                                               input int unsigned dw);
      return (t > dw - 2) ? dw - 2 : t;
   endfunction

endpackage

// File: rtl/ms_es_by4_stream_decoder_popcount.sv
// ---------------------------------------------------------------------------
// sc_popcount
// Purely combinational ones counter for one beat of stochastic lanes.
//
// Ports:
//   lanes_in  in   LANES           stochastic bits of the current beat
//   count     out  $clog2(LANES+1) number of ones in lanes_in
// ---------------------------------------------------------------------------
module sc_popcount #(
   parameter int LANES = 4,
   parameter int CW    = $clog2(LANES + 1)
) (
   input  logic [LANES-1:0] lanes_in,
   output logic [CW-1:0]    count
);

   // Ripple sum over the lanes; LANES is small so a simple chain is fine.
   always_comb begin
      count = '0;
      for (int i = 0; i < LANES; i++) begin
         count = count + CW'(lanes_in[i]);
      end
   end

endmodule

// File: rtl/ms_es_by4_stream_decoder.sv
// ---------------------------------------------------------------------------
// ms_es_by4_stream_decoder
// Stochastic-to-binary decoder at the end of the by4 stochastic datapath.
// Counts the ones of a unipolar bitstream consumed LANES bits per beat.
// In early-stop mode only 2^(DATA_WIDTH-t) bits are observed and the count
// is rescaled by a left shift of t, so the output keeps full-stream scale.
//
// Ports:
//   clk           in   1      rising-edge clock
//   rst           in   1      asynchronous active-high reset
//   en            in   1      global enable, low freezes every register
//   start         in   1      begin a conversion (only honoured in IDLE)
//   trunc         in   TW     early-stop shift, latched at start
//   stream_valid  in   1      stream_in carries a valid beat
//   stream_in     in   LANES  stochastic bits, lane 0 is the earliest
//   bin_data_out  out  WXIP1  decoded count << t, held until next result
//   done          out  1      high for the single DONE cycle
//   busy          out  1      high while accumulating
// ---------------------------------------------------------------------------
module ms_es_by4_stream_decoder
   import ms_es_dec_pkg::*;
#(
   parameter int DATA_WIDTH = 5,
   parameter int LANES      = 4,
   parameter int WXIP1      = 6,
   parameter int TW         = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             start,
   input  logic [TW-1:0]    trunc,
   input  logic             stream_valid,
   input  logic [LANES-1:0] stream_in,
   output logic [WXIP1-1:0] bin_data_out,
   output logic             done,
   output logic             busy
);

   localparam int BEATS_FULL = (2 ** DATA_WIDTH) / LANES;
   localparam int BCW        = $clog2(BEATS_FULL + 1);
   localparam int CW         = $clog2(LANES + 1);
   localparam int AW         = DATA_WIDTH + 1;

   state_t             state;
   state_t             state_next;
   logic [AW-1:0]      acc;
   logic [AW-1:0]      acc_sum;
   logic [BCW-1:0]     beats_left;
   logic [BCW-1:0]     window_beats;
   logic [TW-1:0]      t_reg;
   logic [TW-1:0]      t_clamped;
   logic [CW-1:0]      pop;
   logic               beat_take;
   logic               last_beat;
   logic [WXIP1-1:0]   result;

   sc_popcount #(
      .LANES (LANES),
      .CW    (CW)
   ) u_popcount (
      .lanes_in (stream_in),
      .count    (pop)
   );

   // Clamped shift and the beat budget it implies; a shift of t halves the
   // window t times, so the budget is simply the full beat count >> t.
   always_comb begin
      t_clamped    = TW'(clamp_trunc(32'(trunc), DATA_WIDTH));
      window_beats = BCW'(BEATS_FULL >> t_clamped);
   end

   // Running sum including the current beat; the final beat is folded into
   // the result in the same cycle it is accepted so DONE shows it directly.
   always_comb begin
      acc_sum   = acc + AW'(pop);
      result    = WXIP1'(acc_sum) << t_reg;
      beat_take = (state == ACCUM) && stream_valid;
      last_beat = beat_take && (beats_left == BCW'(1));
   end

   // State register; en low freezes the FSM, including a pending DONE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else if (en) begin
         state <= state_next;
      end
   end

   // Next-state logic. start is only looked at in IDLE, so holding it high
   // through ACCUM/DONE never restarts a conversion in flight.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = ACCUM;
         ACCUM:   if (last_beat) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Output decode straight from the state so done/busy freeze with it.
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state)
         ACCUM:   busy = 1'b1;
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   // Datapath: shift latch, accumulator, beat counter and result register.
   // bin_data_out loads on the edge that accepts the last beat, which is the
   // same edge that enters DONE, so result and done appear together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc          <= '0;
         beats_left   <= '0;
         t_reg        <= '0;
         bin_data_out <= '0;
      end else if (en) begin
         case (state)
            IDLE: begin
               if (start) begin
                  t_reg      <= t_clamped;
                  acc        <= '0;
                  beats_left <= window_beats;
               end
            end
            ACCUM: begin
               if (beat_take) begin
                  acc        <= acc_sum;
                  beats_left <= beats_left - BCW'(1);
                  if (last_beat) begin
                     bin_data_out <= result;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ms_es_by4_stream_decoder.sv
// ---------------------------------------------------------------------------
// tb_ms_es_by4_stream_decoder
// Self-checking bench for the by4 stream decoder. A behavioural model keeps
// the accepted stream bits of the current conversion in a queue and, once the
// window is full, predicts the shifted ones count. A single negedge process
// compares busy/done/bin_data_out against the model every cycle and then
// advances the model with the inputs the DUT will sample on the next edge.
// ---------------------------------------------------------------------------
module tb_ms_es_by4_stream_decoder;

   localparam int DW    = 5;
   localparam int LN    = 4;
   localparam int WX    = 6;
   localparam int TWB   = 3;

   logic           clk;
   logic           rst;
   logic           en;
   logic           start;
   logic [TWB-1:0] trunc;
   logic           stream_valid;
   logic [LN-1:0]  stream_in;
   logic [WX-1:0]  bin_data_out;
   logic           done;
   logic           busy;

   int checks;
   int passes;

   // model state
   bit   m_collect;
   bit   m_done;
   int   m_out;
   int   m_t;
   int   m_window;
   bit   m_bits[$];

   // observation counters
   int   busy_cycles;
   int   done_pulses;
   bit   done_prev;

   ms_es_by4_stream_decoder #(
      .DATA_WIDTH (DW),
      .LANES      (LN),
      .WXIP1      (WX),
      .TW         (TWB)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .start        (start),
      .trunc        (trunc),
      .stream_valid (stream_valid),
      .stream_in    (stream_in),
      .bin_data_out (bin_data_out),
      .done         (done),
      .busy         (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One comparison: counts it and reports a failure line when it differs.
   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual == expected) begin
         passes++;
      end else begin
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Drive one cycle of inputs; they are applied just after a rising edge
   // and sampled by the DUT on the following one.
   task automatic applyStimulus(input bit e, input bit s, input int tr,
                                input bit v, input logic [LN-1:0] d);
      en           = e;
      start        = s;
      trunc        = TWB'(tr);
      stream_valid = v;
      stream_in    = d;
      @(posedge clk);
      #1;
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 0, '0);
   endtask

   task automatic pulseReset();
      rst = 1'b1;
      applyStimulus(1, 0, 0, 0, '0);
      rst = 1'b0;
   endtask

   // Compare against the model, then advance the model by one clock.
   always @(negedge clk) begin
      int ones;
      if (rst) begin
         m_collect = 0;
         m_done    = 0;
         m_out     = 0;
         m_bits.delete();
      end
      checkOutput("busy", int'(busy), int'(m_collect));
      checkOutput("done", int'(done), int'(m_done));
      checkOutput("bin_data_out", int'(bin_data_out), m_out);
      if (busy) busy_cycles++;
      if (done && !done_prev) done_pulses++;
      done_prev = done;
      if (!rst && en) begin
         if (m_done) begin
            m_done = 0;
         end else if (m_collect) begin
            if (stream_valid) begin
               for (int i = 0; i < LN; i++) m_bits.push_back(stream_in[i]);
               if (m_bits.size() >= m_window) begin
                  ones = 0;
                  foreach (m_bits[k]) ones += int'(m_bits[k]);
                  m_out     = ones << m_t;
                  m_collect = 0;
                  m_done    = 1;
               end
            end
         end else if (start) begin
            m_t      = (int'(trunc) > DW - 2) ? DW - 2 : int'(trunc);
            m_window = 2 ** (DW - m_t);
            m_bits.delete();
            m_collect = 1;
         end
      end
   end

   initial begin
      int base_busy;
      int base_done;
      checks      = 0;
      passes      = 0;
      m_collect   = 0;
      m_done      = 0;
      m_out       = 0;
      busy_cycles = 0;
      done_pulses = 0;
      done_prev   = 0;
      rst          = 1'b1;
      en           = 1'b1;
      start        = 1'b0;
      trunc        = '0;
      stream_valid = 1'b0;
      stream_in    = '0;
      @(posedge clk);
      #1;
      checkOutput("reset_bin", int'(bin_data_out), 0);
      checkOutput("reset_busy", int'(busy), 0);
      checkOutput("reset_done", int'(done), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      idleCycles(2);

      // full stream of all ones
      base_busy = busy_cycles;
      base_done = done_pulses;
      applyStimulus(1, 1, 0, 0, '0);
      for (int i = 0; i < 8; i++) applyStimulus(1, 0, 0, 1, 4'b1111);
      checkOutput("t1_done", int'(done), 1);
      checkOutput("t1_result", int'(bin_data_out), 32);
      checkOutput("t1_model", m_out, 32);
      idleCycles(3);
      checkOutput("t1_busy_cycles", busy_cycles - base_busy, 8);
      checkOutput("t1_done_pulses", done_pulses - base_done, 1);

      // gapped stream, alternate beats invalid
      base_done = done_pulses;
      applyStimulus(1, 1, 0, 0, '0);
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1, 0, 0, 1, (i % 2 == 0) ? 4'b0101 : 4'b0011);
         if (i != 7) applyStimulus(1, 0, 0, 0, 4'b1111);
      end
      checkOutput("t2_result", int'(bin_data_out), 16);
      checkOutput("t2_model", m_out, 16);
      idleCycles(3);
      checkOutput("t2_done_pulses", done_pulses - base_done, 1);

      // early stop, t=2 and clamped t=5
      applyStimulus(1, 1, 2, 0, '0);
      applyStimulus(1, 0, 0, 1, 4'b1011);
      applyStimulus(1, 0, 0, 1, 4'b1011);
      checkOutput("t3a_done", int'(done), 1);
      checkOutput("t3a_result", int'(bin_data_out), 24);
      idleCycles(2);
      applyStimulus(1, 1, 5, 0, '0);
      applyStimulus(1, 0, 0, 1, 4'b0001);
      checkOutput("t3b_done", int'(done), 1);
      checkOutput("t3b_result", int'(bin_data_out), 8);
      checkOutput("t3b_model", m_out, 8);
      idleCycles(2);

      // enable gaps mid-accumulation and in the DONE cycle
      base_done = done_pulses;
      applyStimulus(1, 1, 0, 0, '0);
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1, 0, 0, 1, (i % 2 == 0) ? 4'b1110 : 4'b0011);
         if (i == 3) for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0, 1, 4'b1111);
      end
      applyStimulus(0, 1, 0, 1, 4'b1111);
      applyStimulus(0, 1, 0, 1, 4'b1111);
      checkOutput("t4_done_frozen", int'(done), 1);
      checkOutput("t4_result", int'(bin_data_out), 20);
      applyStimulus(1, 0, 0, 0, '0);
      checkOutput("t4_done_cleared", int'(done), 0);
      idleCycles(2);
      checkOutput("t4_done_pulses", done_pulses - base_done, 1);

      // reset mid-accumulation, then a clean run
      base_done = done_pulses;
      applyStimulus(1, 1, 0, 0, '0);
      for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 1, 4'b1111);
      pulseReset();
      checkOutput("t5_bin_zero", int'(bin_data_out), 0);
      checkOutput("t5_busy_zero", int'(busy), 0);
      idleCycles(4);
      checkOutput("t5_no_done", done_pulses - base_done, 0);
      applyStimulus(1, 1, 0, 0, '0);
      for (int i = 0; i < 8; i++) applyStimulus(1, 0, 0, 1, 4'b1000);
      checkOutput("t5_result", int'(bin_data_out), 8);
      idleCycles(2);

      // start held high across ACCUM and DONE
      base_done = done_pulses;
      applyStimulus(1, 1, 0, 0, '0);
      for (int i = 0; i < 8; i++) applyStimulus(1, 1, 0, 1, 4'b0110);
      checkOutput("t6_first_result", int'(bin_data_out), 16);
      applyStimulus(1, 1, 0, 0, '0);
      checkOutput("t6_idle_busy", int'(busy), 0);
      applyStimulus(1, 1, 0, 0, '0);
      checkOutput("t6_restart_busy", int'(busy), 1);
      for (int i = 0; i < 8; i++) applyStimulus(1, 0, 0, 1, 4'b0111);
      checkOutput("t6_second_result", int'(bin_data_out), 24);
      idleCycles(2);
      checkOutput("t6_done_pulses", done_pulses - base_done, 2);

      // randomized traffic, checked cycle by cycle against the model
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 399) == 0) begin
            pulseReset();
         end else begin
            applyStimulus($urandom_range(0, 9) != 0,
                          $urandom_range(0, 3) == 0,
                          int'($urandom_range(0, 7)),
                          $urandom_range(0, 3) != 0,
                          LN'($urandom));
         end
      end
      idleCycles(40);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
